// File: rtl/det4_seq_ctrl_pkg.sv
// Shared types and helpers for the sequential 4x4 determinant controller.
// Matrices are row-major 8-bit signed elements, a00 in the top byte.
package det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int DET_MIN = -128;
    localparam int DET_MAX = 127;

    function automatic logic [7:0] elem(input logic [127:0] m, input int r, input int c);
        return m[(15 - (r * 4 + c)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/det4_seq_ctrl_if.sv
// Handshake between the instruction decoder (master) and the det4 controller (slave).
interface det4_seq_ctrl_if;
    logic              start;
    logic [127:0]      matrix;
    logic              busy;
    logic              done;
    logic signed [7:0] det;
    logic              ovf;

    modport master (output start, matrix, input busy, done, det, ovf);
    modport slave  (input start, matrix, output busy, done, det, ovf);
endinterface

// File: rtl/det3.sv
// 3x3 signed determinant evaluator: low 8 bits of the exact result plus range overflow.
module det3
    import det_pkg::*;
(
    input  logic [71:0]       m3,
    output logic signed [7:0] det,
    output logic              ovf
);

    logic signed [31:0] e [3][3];
    logic signed [31:0] full;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                e[r][c] = 32'($signed(m3[(8 - (r * 3 + c)) * 8 +: 8]));
            end
        end
        full = e[0][0] * (e[1][1] * e[2][2] - e[1][2] * e[2][1])
             - e[0][1] * (e[1][0] * e[2][2] - e[1][2] * e[2][0])
             + e[0][2] * (e[1][0] * e[2][1] - e[1][1] * e[2][0]);
        det  = full[7:0];
        ovf  = (full < DET_MIN) || (full > DET_MAX);
    end

endmodule

// File: rtl/det4_minor_mux.sv
// Selects the 3x3 minor of rows 1-3 with column col removed, in det3 input layout.
module det4_minor_mux
    import det_pkg::*;
(
    input  logic [127:0] mreg,
    input  logic [1:0]   col,
    output logic [71:0]  minor
);

    always_comb begin
        minor = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                minor[(8 - (r * 3 + c)) * 8 +: 8] = elem(mreg, r + 1, (c < int'(col)) ? c : c + 1);
            end
        end
    end

endmodule

// File: rtl/det4_seq_ctrl.sv
// Sequential 4x4 determinant: one first-row cofactor per cycle through a shared det3.
//  state | meaning
//  IDLE  | waiting for start; holds last det/ovf
//  CALC  | accumulating a0j * cofactor for column col
module det4_seq_ctrl
    import det_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0,
    parameter int ACC_W     = 18
) (
    input  logic            clk,
    input  logic            rst,
    det4_seq_ctrl_if.slave  bus
);

    state_t                   state_q, state_d;
    logic [1:0]               col_q, col_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic                     sticky_q, sticky_d, sticky_sum;
    logic [127:0]             mreg_q, mreg_d;
    logic                     done_q, done_d;
    logic signed [7:0]        det_q, det_d;
    logic                     ovf_q, ovf_d;

    logic [71:0]              minor;
    logic signed [7:0]        m_det, a_el, s_val;
    logic                     m_ovf;
    logic signed [15:0]       prod;
    logic [3:0]               nz_in, nz_mreg;
    logic [1:0]               first_in, nxt_col;
    logic                     last;

    det4_minor_mux u_mux (.mreg(mreg_q), .col(col_q), .minor(minor));
    det3           u_det3 (.m3(minor), .det(m_det), .ovf(m_ovf));

    always_comb begin
        nz_in    = '0;
        nz_mreg  = '0;
        first_in = '0;
        for (int j = 0; j < 4; j++) begin
            nz_in[j]   = elem(bus.matrix, 0, j) != 8'd0;
            nz_mreg[j] = elem(mreg_q, 0, j) != 8'd0;
        end
        for (int j = 3; j >= 0; j--) begin
            if (nz_in[j]) first_in = 2'(j);
        end

        nxt_col = col_q + 2'd1;
        last    = (col_q == 2'd3);
        if (ZERO_SKIP) begin
            last    = 1'b1;
            nxt_col = col_q;
            for (int j = 3; j >= 0; j--) begin
                if (j > int'(col_q) && nz_mreg[j]) begin
                    last    = 1'b0;
                    nxt_col = 2'(j);
                end
            end
        end
    end

    // Negating -128 wraps; the odd-column -128 case is flagged instead of widened.
    always_comb begin
        a_el       = $signed(elem(mreg_q, 0, int'(col_q)));
        s_val      = col_q[0] ? -m_det : m_det;
        prod       = 16'(a_el) * 16'(s_val);
        acc_sum    = acc_q + ACC_W'(prod);
        sticky_sum = sticky_q | m_ovf | (col_q[0] & (m_det == 8'sh80))
                   | (prod < 16'(DET_MIN)) | (prod > 16'(DET_MAX));
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        mreg_d   = mreg_q;
        done_d   = 1'b0;
        det_d    = det_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mreg_d   = bus.matrix;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    col_d    = 2'd0;
                    state_d  = CALC;
                    if (ZERO_SKIP) begin
                        col_d = first_in;
                        if (nz_in == 4'd0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            det_d   = '0;
                            ovf_d   = 1'b0;
                        end
                    end
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                sticky_d = sticky_sum;
                col_d    = nxt_col;
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    det_d   = acc_sum[7:0];
                    ovf_d   = sticky_sum | (acc_sum < ACC_W'(DET_MIN)) | (acc_sum > ACC_W'(DET_MAX));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            mreg_q   <= '0;
            done_q   <= 1'b0;
            det_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            mreg_q   <= mreg_d;
            done_q   <= done_d;
            det_q    <= det_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = done_q;
    assign bus.det  = det_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_det4_seq_ctrl.sv
// Bench for det4_seq_ctrl: one instance without and one with zero-column skipping,
// checked against a Laplace-expansion reference model.
module tb_det4_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int              lat0, lat1, busy0, dcnt0, dcnt1;
    logic [7:0]      det0, det1;
    logic            ovf0, ovf1;

    det4_seq_ctrl_if bus0 ();
    det4_seq_ctrl_if bus1 ();

    det4_seq_ctrl #(.ZERO_SKIP(1'b0), .ACC_W(18)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    det4_seq_ctrl #(.ZERO_SKIP(1'b1), .ACC_W(18)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] set_el(input logic [127:0] m, input int r, input int c, input int v);
        logic [127:0] t;
        t = m;
        t[127 - 8 * (4 * r + c) -: 8] = 8'(v);
        return t;
    endfunction

    function automatic logic [127:0] diag(input int v);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 4; i++) t = set_el(t, i, i, v);
        return t;
    endfunction

    function automatic logic [127:0] rnd_matrix(input bit wide);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            if (wide) t = set_el(t, i / 4, i % 4, int'($urandom_range(255)));
            else      t = set_el(t, i / 4, i % 4, int'($urandom_range(8)) - 4);
        end
        return t;
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Laplace expansion along row 0 with exact integer minors.
    function automatic void model(input logic [127:0] m, input bit zs,
                                  output logic [7:0] d, output logic o, output int lat);
        int a [4][4];
        int cols [3];
        int acc, mm, m8, s, p, nnz, k;
        bit st;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = int'($signed(m[127 - 8 * (4 * r + c) -: 8]));
        acc = 0; st = 0; nnz = 0;
        for (int j = 0; j < 4; j++) begin
            if (zs && a[0][j] == 0) continue;
            nnz++;
            k = 0;
            for (int c = 0; c < 4; c++) if (c != j) begin cols[k] = c; k++; end
            mm = a[1][cols[0]] * (a[2][cols[1]] * a[3][cols[2]] - a[2][cols[2]] * a[3][cols[1]])
               - a[1][cols[1]] * (a[2][cols[0]] * a[3][cols[2]] - a[2][cols[2]] * a[3][cols[0]])
               + a[1][cols[2]] * (a[2][cols[0]] * a[3][cols[1]] - a[2][cols[1]] * a[3][cols[0]]);
            m8 = ((mm + 128) & 255) - 128;
            s  = (j % 2 == 1) ? -m8 : m8;
            p  = a[0][j] * s;
            if (mm < -128 || mm > 127 || (j % 2 == 1 && m8 == -128) || p < -128 || p > 127) st = 1;
            acc += p;
        end
        d   = 8'(acc);
        o   = st || acc < -128 || acc > 127;
        lat = zs ? nnz : 4;
    endfunction

    // Start both instances with m, scramble the input afterwards, record what each reports.
    task automatic launch(input logic [127:0] m);
        @(negedge clk);
        bus0.start = 1'b1; bus0.matrix = m;
        bus1.start = 1'b1; bus1.matrix = m;
        @(negedge clk);
        bus0.start = 1'b0; bus0.matrix = junk();
        bus1.start = 1'b0; bus1.matrix = junk();
        lat0 = -1; lat1 = -1; busy0 = 0; dcnt0 = 0; dcnt1 = 0;
        det0 = 'x; det1 = 'x; ovf0 = 'x; ovf1 = 'x;
        for (int k = 0; k < 8; k++) begin
            if (bus0.done) begin
                dcnt0++;
                if (lat0 < 0) begin lat0 = k; det0 = bus0.det; ovf0 = bus0.ovf; end
            end
            if (bus1.done) begin
                dcnt1++;
                if (lat1 < 0) begin lat1 = k; det1 = bus1.det; ovf1 = bus1.ovf; end
            end
            if (bus0.busy) busy0++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus0.start = 1'b0; bus0.matrix = '0;
        bus1.start = 1'b0; bus1.matrix = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus0.busy, bus0.done, bus0.ovf, bus0.det} !== 11'd0) begin
            failures++;
            $display("FAIL reset0 busy/done/ovf/det got=%b exp=0", {bus0.busy, bus0.done, bus0.ovf, bus0.det});
        end
        checks++;
        if ({bus1.busy, bus1.done, bus1.ovf, bus1.det} !== 11'd0) begin
            failures++;
            $display("FAIL reset1 busy/done/ovf/det got=%b exp=0", {bus1.busy, bus1.done, bus1.ovf, bus1.det});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        launch(diag(1));
        checks++; if (det0 !== 8'd1 || ovf0 !== 1'b0) begin failures++; $display("FAIL ident0 det=%0d ovf=%b exp 1/0", det0, ovf0); end
        checks++; if (lat0 !== 4) begin failures++; $display("FAIL ident0_lat got=%0d exp=4", lat0); end
        checks++; if (busy0 !== 4) begin failures++; $display("FAIL ident0_busy got=%0d exp=4", busy0); end
        checks++; if (dcnt0 !== 1) begin failures++; $display("FAIL ident0_done_pulses got=%0d exp=1", dcnt0); end
        checks++; if (det1 !== 8'd1 || ovf1 !== 1'b0) begin failures++; $display("FAIL ident1 det=%0d ovf=%b exp 1/0", det1, ovf1); end
        checks++; if (lat1 !== 1) begin failures++; $display("FAIL ident1_lat got=%0d exp=1", lat1); end
        checks++; if (dcnt1 !== 1) begin failures++; $display("FAIL ident1_done_pulses got=%0d exp=1", dcnt1); end
    endtask

    task automatic test_zero_row();
        launch(set_el(diag(1), 0, 0, 0));
        checks++; if (lat1 !== 0) begin failures++; $display("FAIL zrow1_lat got=%0d exp=0", lat1); end
        checks++; if (det1 !== 8'd0 || ovf1 !== 1'b0) begin failures++; $display("FAIL zrow1 det=%0d ovf=%b exp 0/0", det1, ovf1); end
        checks++; if (lat0 !== 4 || det0 !== 8'd0 || ovf0 !== 1'b0) begin
            failures++; $display("FAIL zrow0 lat=%0d det=%0d ovf=%b exp 4/0/0", lat0, det0, ovf0);
        end
    endtask

    task automatic test_known();
        logic [127:0] m;
        m = set_el(diag(3), 0, 0, 2);
        launch(m);
        checks++; if (det0 !== 8'h36 || ovf0 !== 1'b0) begin failures++; $display("FAIL k54_0 det=%h ovf=%b exp 36/0", det0, ovf0); end
        checks++; if (det1 !== 8'h36 || ovf1 !== 1'b0 || lat1 !== 1) begin
            failures++; $display("FAIL k54_1 det=%h ovf=%b lat=%0d exp 36/0/1", det1, ovf1, lat1);
        end
        launch(diag(5));
        checks++; if (det0 !== 8'h71 || ovf0 !== 1'b1) begin failures++; $display("FAIL diag5_0 det=%h ovf=%b exp 71/1", det0, ovf0); end
        checks++; if (det1 !== 8'h71 || ovf1 !== 1'b1) begin failures++; $display("FAIL diag5_1 det=%h ovf=%b exp 71/1", det1, ovf1); end
    endtask

    task automatic test_random();
        logic [127:0] m;
        logic [7:0]   ed;
        logic         eo;
        int           el;
        for (int it = 0; it < 40; it++) begin
            m = rnd_matrix(it % 4 == 3);
            if (it % 5 == 1) m = set_el(m, 0, it % 4, 0);
            launch(m);
            model(m, 1'b0, ed, eo, el);
            checks++;
            if (det0 !== ed || ovf0 !== eo || lat0 !== el || busy0 !== 4 || dcnt0 !== 1) begin
                failures++;
                $display("FAIL rand0 it=%0d det=%h ovf=%b lat=%0d busy=%0d pulses=%0d exp det=%h ovf=%b lat=%0d busy=4 pulses=1",
                         it, det0, ovf0, lat0, busy0, dcnt0, ed, eo, el);
            end
            model(m, 1'b1, ed, eo, el);
            checks++;
            if (det1 !== ed || ovf1 !== eo || lat1 !== el || dcnt1 !== 1) begin
                failures++;
                $display("FAIL rand1 it=%0d det=%h ovf=%b lat=%0d pulses=%0d exp det=%h ovf=%b lat=%0d pulses=1",
                         it, det1, ovf1, lat1, dcnt1, ed, eo, el);
            end
        end
    endtask

    // Leaves the bench on the negedge where dut0's done is visible.
    task automatic test_ignore_start();
        logic [127:0] m1, m2;
        logic [7:0]   d1, d2;
        logic         o1, o2;
        int           el, got;
        m1 = rnd_matrix(1'b0);
        model(m1, 1'b0, d1, o1, el);
        for (int t = 0; t < 50; t++) begin
            m2 = rnd_matrix(1'b0);
            model(m2, 1'b0, d2, o2, el);
            if (d2 != d1) break;
        end
        @(negedge clk);
        bus0.start = 1'b1; bus0.matrix = m1;
        @(negedge clk);
        bus0.matrix = m2;
        repeat (3) @(negedge clk);
        bus0.start = 1'b0;
        got = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus0.done) begin got = k; break; end
        end
        checks++; if (got !== 0) begin failures++; $display("FAIL ignore_lat got=%0d exp=0", got); end
        checks++; if (bus0.det !== d1 || bus0.ovf !== o1) begin
            failures++; $display("FAIL ignore_result det=%h ovf=%b exp det=%h ovf=%b", bus0.det, bus0.ovf, d1, o1);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] m3;
        logic [7:0]   ed;
        logic         eo;
        int           el, got;
        m3 = set_el(diag(2), 0, 3, 1);
        model(m3, 1'b0, ed, eo, el);
        checks++; if (bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin
            failures++; $display("FAIL b2b_entry done=%b busy=%b exp 1/0", bus0.done, bus0.busy);
        end
        bus0.start = 1'b1; bus0.matrix = m3;
        @(negedge clk);
        bus0.start = 1'b0; bus0.matrix = junk();
        checks++; if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
            failures++; $display("FAIL b2b_accept busy=%b done=%b exp 1/0", bus0.busy, bus0.done);
        end
        got = -1;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            if (bus0.done) begin got = k; break; end
        end
        checks++; if (got !== 4) begin failures++; $display("FAIL b2b_lat got=%0d exp=4", got); end
        checks++; if (bus0.det !== ed || bus0.ovf !== eo) begin
            failures++; $display("FAIL b2b_result det=%h ovf=%b exp det=%h ovf=%b", bus0.det, bus0.ovf, ed, eo);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [127:0] m;
        logic [7:0]   ed;
        logic         eo;
        int           el, seen;
        launch(diag(5));
        m = diag(2);
        for (int c = 0; c < 4; c++) m = set_el(m, 0, c, c + 1);
        @(negedge clk);
        bus0.start = 1'b1; bus0.matrix = m;
        bus1.start = 1'b1; bus1.matrix = m;
        @(negedge clk);
        bus0.start = 1'b0; bus1.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if ({bus0.busy, bus0.done, bus0.ovf, bus0.det} !== 11'd0) begin
            failures++; $display("FAIL midrst0 busy/done/ovf/det got=%b exp=0", {bus0.busy, bus0.done, bus0.ovf, bus0.det});
        end
        checks++; if ({bus1.busy, bus1.done, bus1.ovf, bus1.det} !== 11'd0) begin
            failures++; $display("FAIL midrst1 busy/done/ovf/det got=%b exp=0", {bus1.busy, bus1.done, bus1.ovf, bus1.det});
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus0.done || bus1.done) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
        m = rnd_matrix(1'b0);
        launch(m);
        model(m, 1'b0, ed, eo, el);
        checks++; if (det0 !== ed || ovf0 !== eo || lat0 !== el) begin
            failures++; $display("FAIL after_rst0 det=%h ovf=%b lat=%0d exp %h/%b/%0d", det0, ovf0, lat0, ed, eo, el);
        end
        model(m, 1'b1, ed, eo, el);
        checks++; if (det1 !== ed || ovf1 !== eo || lat1 !== el) begin
            failures++; $display("FAIL after_rst1 det=%h ovf=%b lat=%0d exp %h/%b/%0d", det1, ovf1, lat1, ed, eo, el);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_identity();
        test_zero_row();
        test_known();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
